// File: rtl/flush_pump_pkg.sv
// ---------------------------------------------------------------------------
// flush_pump_pkg
// Shared definitions for the fluid board pump PWM generators.
//   - Default counter width, PWM period and ramp step used by the pump
//     generators on the board.
//   - Flush pump FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package flush_pump_pkg;

   localparam int FP_CNT_W     = 16;
   localparam int FP_PERIOD    = 2500;
   localparam int FP_RAMP_STEP = 16;

   typedef enum logic [1:0] {
      FP_IDLE      = 2'd0,
      FP_RUN       = 2'd1,
      FP_RAMP_DOWN = 2'd2
   } fp_state_e;

endpackage

// File: rtl/flush_pump_duty_ramp.sv
// ---------------------------------------------------------------------------
// flush_pump_duty_ramp
// Combinational slew limiter: moves the current duty toward the target by
// at most one step. If the target is within one step it is taken directly.
// Ports:
//   duty_cur   in  CNT_W : duty currently applied
//   duty_tgt   in  CNT_W : duty being ramped toward
//   duty_step  in  CNT_W : largest allowed change
//   duty_next  out CNT_W : duty to apply for the next period
// ---------------------------------------------------------------------------
module flush_pump_duty_ramp
   import flush_pump_pkg::*;
#(
   parameter int CNT_W = FP_CNT_W
) (
   input  logic [CNT_W-1:0] duty_cur,
   input  logic [CNT_W-1:0] duty_tgt,
   input  logic [CNT_W-1:0] duty_step,
   output logic [CNT_W-1:0] duty_next
);

   logic [CNT_W:0] cur_x;
   logic [CNT_W:0] tgt_x;
   logic [CNT_W:0] step_x;
   logic [CNT_W:0] diff_x;

   // The distance is taken in one extra bit so neither direction can wrap.
   // When the target is further than one step away, the result stays strictly
   // between current and target, so cur+step and cur-step always fit.
   always_comb begin
      cur_x     = {1'b0, duty_cur};
      tgt_x     = {1'b0, duty_tgt};
      step_x    = {1'b0, duty_step};
      diff_x    = '0;
      duty_next = duty_tgt;
      if (tgt_x >= cur_x) begin
         diff_x = tgt_x - cur_x;
         if (diff_x > step_x) begin
            duty_next = duty_cur + duty_step;
         end
      end else begin
         diff_x = cur_x - tgt_x;
         if (diff_x > step_x) begin
            duty_next = duty_cur - duty_step;
         end
      end
   end

endmodule

// File: rtl/flush_pump_pwm_gen.sv
// ---------------------------------------------------------------------------
// flush_pump_pwm_gen
// Fixed-frequency PWM drive for the flush pump gate with a slew-limited duty
// that is updated once per period, and a ramp down to zero on disable.
// Ports:
//   clk           in  1     : system clock
//   reset_n       in  1     : synchronous reset, active low
//   enable        in  1     : pump run request (level)
//   duty_cycle    in  32    : target duty word, low CNT_W bits used
//   pwm_out       out 1     : registered PWM drive, high = pump on
//   period_start  out 1     : pulse on the first clock of each active period
//   duty_active   out CNT_W : duty currently applied, in counts
//   saturated     out 1     : high while requested duty exceeds PERIOD
// ---------------------------------------------------------------------------
module flush_pump_pwm_gen
   import flush_pump_pkg::*;
#(
   parameter int CNT_W     = FP_CNT_W,
   parameter int PERIOD    = FP_PERIOD,
   parameter int RAMP_STEP = FP_RAMP_STEP
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [31:0]      duty_cycle,
   output logic             pwm_out,
   output logic             period_start,
   output logic [CNT_W-1:0] duty_active,
   output logic             saturated
);

   localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] STEP_C   = CNT_W'(RAMP_STEP);

   fp_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   logic             pwm_q, pwm_d;
   logic             period_start_q, period_start_d;
   logic             saturated_q, saturated_d;

   logic [CNT_W-1:0] duty_low;
   logic [CNT_W-1:0] target_c;
   logic [CNT_W-1:0] ramp_tgt;
   logic [CNT_W-1:0] ramp_next;
   logic [31-CNT_W:0] unused_duty_hi;

   assign duty_low       = duty_cycle[CNT_W-1:0];
   assign unused_duty_hi = duty_cycle[31:CNT_W];

   // Clamp the requested duty to a full period. While ramping down with the
   // run request still low the pump is steered toward zero instead; once the
   // request returns the real target applies again at the same boundary.
   always_comb begin
      target_c = duty_low;
      if (duty_low > PERIOD_C) begin
         target_c = PERIOD_C;
      end
      ramp_tgt = target_c;
      if (state_q == FP_RAMP_DOWN && !enable) begin
         ramp_tgt = '0;
      end
   end

   flush_pump_duty_ramp #(
      .CNT_W (CNT_W)
   ) u_ramp (
      .duty_cur  (duty_q),
      .duty_tgt  (ramp_tgt),
      .duty_step (STEP_C),
      .duty_next (ramp_next)
   );

   // Period counter, FSM and duty update. The duty only changes on a period
   // boundary (the IDLE->RUN cycle or the last count of a period), so the
   // requested duty is effectively sampled on that one clock. Leaving RUN does
   // not touch the counter, so the period in flight completes unchanged.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      duty_d  = duty_q;
      case (state_q)
         FP_IDLE: begin
            cnt_d  = '0;
            duty_d = '0;
            if (enable) begin
               state_d = FP_RUN;
               duty_d  = ramp_next;
            end
         end
         FP_RUN: begin
            if (cnt_q == LAST_C) begin
               cnt_d  = '0;
               duty_d = ramp_next;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (!enable) begin
               state_d = FP_RAMP_DOWN;
            end
         end
         FP_RAMP_DOWN: begin
            if (cnt_q == LAST_C) begin
               cnt_d  = '0;
               duty_d = ramp_next;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (enable) begin
               state_d = FP_RUN;
            end else if (cnt_q == LAST_C && ramp_next == '0) begin
               state_d = FP_IDLE;
               cnt_d   = '0;
               duty_d  = '0;
            end
         end
         default: begin
            state_d = FP_IDLE;
            cnt_d   = '0;
            duty_d  = '0;
         end
      endcase
   end

   // Outputs are computed from the next counter and duty so the registered
   // PWM edge lines up with the counter value it belongs to.
   always_comb begin
      pwm_d          = (state_d != FP_IDLE) && (cnt_d < duty_d);
      period_start_d = (state_d != FP_IDLE) && (cnt_d == '0);
      saturated_d    = (duty_low > PERIOD_C);
   end

   // State register with synchronous active-low reset straight to IDLE; no
   // ramp-down is performed on reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= FP_IDLE;
         cnt_q          <= '0;
         duty_q         <= '0;
         pwm_q          <= 1'b0;
         period_start_q <= 1'b0;
         saturated_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         duty_q         <= duty_d;
         pwm_q          <= pwm_d;
         period_start_q <= period_start_d;
         saturated_q    <= saturated_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign period_start = period_start_q;
   assign duty_active  = duty_q;
   assign saturated    = saturated_q;

endmodule

// File: tb/tb_flush_pump_pwm_gen.sv
// ---------------------------------------------------------------------------
// tb_flush_pump_pwm_gen
// Directed bench for flush_pump_pwm_gen with PERIOD=100, RAMP_STEP=10.
// No ports.
// ---------------------------------------------------------------------------
module tb_flush_pump_pwm_gen;

   localparam int TB_CNT_W  = 16;
   localparam int TB_PERIOD = 100;
   localparam int TB_STEP   = 10;

   logic                clk;
   logic                reset_n;
   logic                enable;
   logic [31:0]         duty_cycle;
   logic                pwm_out;
   logic                period_start;
   logic [TB_CNT_W-1:0] duty_active;
   logic                saturated;

   int checkCount;
   int errorCount;

   flush_pump_pwm_gen #(
      .CNT_W     (TB_CNT_W),
      .PERIOD    (TB_PERIOD),
      .RAMP_STEP (TB_STEP)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .duty_cycle   (duty_cycle),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .duty_active  (duty_active),
      .saturated    (saturated)
   );

   // 100 MHz free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [31:0] duty);
      enable     = en;
      duty_cycle = duty;
   endtask

   // Advance n clocks and land 1 ns after the edge for sampling.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Advance to the next period_start sample, bounded, returning clocks used.
   task automatic waitPeriodStart(input string tag, output int n);
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!period_start && n < 200);
      checkOutput({tag, " period_start seen"}, 32'(period_start), 32'd1);
   endtask

   // Starting on a period's first clock, count high PWM clocks over a period.
   task automatic measurePeriod(output int highs);
      highs = 0;
      for (int i = 0; i < TB_PERIOD; i++) begin
         highs += int'(pwm_out);
         tick(1);
      end
   endtask

   initial begin
      int highs;
      int n;
      int exp1[6];
      int exp2[6];
      int exp4[7];
      int exp4b[3];
      int psCount;
      int pwmCount;

      exp1  = '{10, 20, 30, 40, 50, 50};
      exp2  = '{45, 35, 25, 15, 5, 0};
      exp4  = '{90, 80, 70, 60, 50, 40, 35};
      exp4b = '{25, 15, 5};
      checkCount = 0;
      errorCount = 0;

      // Test 1: reset with enable high, then ramp up to 50.
      reset_n = 1'b0;
      applyStimulus(1'b1, 32'd50);
      tick(3);
      checkOutput("rst pwm_out", 32'(pwm_out), 32'd0);
      checkOutput("rst period_start", 32'(period_start), 32'd0);
      checkOutput("rst duty_active", 32'(duty_active), 32'd0);
      checkOutput("rst saturated", 32'(saturated), 32'd0);
      reset_n = 1'b1;
      tick(1);
      checkOutput("t1 first period_start", 32'(period_start), 32'd1);
      checkOutput("t1 first pwm_out", 32'(pwm_out), 32'd1);
      for (int i = 0; i < 6; i++) begin
         checkOutput("t1 duty_active", 32'(duty_active), 32'(exp1[i]));
         measurePeriod(highs);
         checkOutput("t1 pwm high clocks", 32'(highs), 32'(exp1[i]));
         checkOutput("t1 period_start", 32'(period_start), 32'd1);
      end

      // Test 2: mid-period change to 55, then ramp to zero staying in RUN.
      tick(30);
      applyStimulus(1'b1, 32'd55);
      tick(1);
      checkOutput("t2 duty held mid-period", 32'(duty_active), 32'd50);
      waitPeriodStart("t2 to 55", n);
      checkOutput("t2 duty 55", 32'(duty_active), 32'd55);
      tick(20);
      applyStimulus(1'b1, 32'hFFFF_0000);
      for (int i = 0; i < 6; i++) begin
         waitPeriodStart("t2 ramp", n);
         checkOutput("t2 ramp boundary spacing", 32'(n), 32'(i == 0 ? 80 : TB_PERIOD));
         checkOutput("t2 ramp duty", 32'(duty_active), 32'(exp2[i]));
      end
      checkOutput("t2 saturated low", 32'(saturated), 32'd0);
      measurePeriod(highs);
      checkOutput("t2 zero duty pwm", 32'(highs), 32'd0);
      checkOutput("t2 still running", 32'(period_start), 32'd1);

      // Test 3: saturating request ramps to a full period.
      applyStimulus(1'b1, 32'd250);
      checkOutput("t3 saturated before edge", 32'(saturated), 32'd0);
      tick(1);
      checkOutput("t3 saturated after edge", 32'(saturated), 32'd1);
      for (int k = 1; k <= 10; k++) begin
         waitPeriodStart("t3 ramp", n);
         checkOutput("t3 ramp duty", 32'(duty_active), 32'(10 * k));
      end
      measurePeriod(highs);
      checkOutput("t3 full duty pwm", 32'(highs), 32'd100);
      applyStimulus(1'b1, 32'd100);
      tick(1);
      checkOutput("t3 saturated cleared", 32'(saturated), 32'd0);

      // Test 4: ramp down to 35, drop enable, ramp to idle.
      applyStimulus(1'b1, 32'd35);
      for (int i = 0; i < 7; i++) begin
         waitPeriodStart("t4 down", n);
         checkOutput("t4 down duty", 32'(duty_active), 32'(exp4[i]));
      end
      tick(10);
      applyStimulus(1'b0, 32'd35);
      tick(1);
      checkOutput("t4 duty unchanged", 32'(duty_active), 32'd35);
      for (int i = 0; i < 3; i++) begin
         waitPeriodStart("t4 ramp_down", n);
         checkOutput("t4 ramp_down duty", 32'(duty_active), 32'(exp4b[i]));
      end
      tick(TB_PERIOD);
      checkOutput("t4 idle duty", 32'(duty_active), 32'd0);
      checkOutput("t4 idle pwm", 32'(pwm_out), 32'd0);
      checkOutput("t4 idle period_start", 32'(period_start), 32'd0);
      psCount  = 0;
      pwmCount = 0;
      for (int i = 0; i < 150; i++) begin
         tick(1);
         psCount  += int'(period_start);
         pwmCount += int'(pwm_out);
      end
      checkOutput("t4 idle period_start count", 32'(psCount), 32'd0);
      checkOutput("t4 idle pwm count", 32'(pwmCount), 32'd0);

      // Test 5: re-enable during ramp-down at 15, counter keeps running.
      applyStimulus(1'b1, 32'd35);
      tick(1);
      checkOutput("t5 restart duty", 32'(duty_active), 32'd10);
      checkOutput("t5 restart period_start", 32'(period_start), 32'd1);
      waitPeriodStart("t5 up", n);
      checkOutput("t5 up duty 20", 32'(duty_active), 32'd20);
      waitPeriodStart("t5 up", n);
      checkOutput("t5 up duty 30", 32'(duty_active), 32'd30);
      waitPeriodStart("t5 up", n);
      checkOutput("t5 up duty 35", 32'(duty_active), 32'd35);
      applyStimulus(1'b0, 32'd35);
      waitPeriodStart("t5 down", n);
      checkOutput("t5 down duty 25", 32'(duty_active), 32'd25);
      waitPeriodStart("t5 down", n);
      checkOutput("t5 down duty 15", 32'(duty_active), 32'd15);
      tick(40);
      applyStimulus(1'b1, 32'd35);
      waitPeriodStart("t5 resume", n);
      checkOutput("t5 no counter reset", 32'(n), 32'd60);
      checkOutput("t5 resume duty 25", 32'(duty_active), 32'd25);
      waitPeriodStart("t5 resume", n);
      checkOutput("t5 resume duty 35", 32'(duty_active), 32'd35);
      measurePeriod(highs);
      checkOutput("t5 pwm high clocks", 32'(highs), 32'd35);

      // Test 6: reset mid-period at duty 40, then restart from 10.
      applyStimulus(1'b1, 32'd40);
      waitPeriodStart("t6 up", n);
      checkOutput("t6 duty 40", 32'(duty_active), 32'd40);
      tick(30);
      reset_n = 1'b0;
      tick(1);
      checkOutput("t6 rst pwm_out", 32'(pwm_out), 32'd0);
      checkOutput("t6 rst period_start", 32'(period_start), 32'd0);
      checkOutput("t6 rst duty_active", 32'(duty_active), 32'd0);
      checkOutput("t6 rst saturated", 32'(saturated), 32'd0);
      reset_n = 1'b1;
      tick(1);
      checkOutput("t6 restart duty", 32'(duty_active), 32'd10);
      checkOutput("t6 restart period_start", 32'(period_start), 32'd1);
      checkOutput("t6 restart pwm", 32'(pwm_out), 32'd1);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
